// File: rtl/timers_pkg.sv
// ============================================================================
// Module   : timers_pkg
// Brief    : Shared constants for the EMC08 timer SFR controller: default SFR
//            addresses, TMOD/TCON bit positions and M1:M0 mode encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package timers_pkg;

  // Default SFR addresses
  localparam logic [7:0] TCON_ADDR_DEF = 8'h88;
  localparam logic [7:0] TMOD_ADDR_DEF = 8'h89;
  localparam logic [7:0] TL0_ADDR_DEF  = 8'h8A;
  localparam logic [7:0] TL1_ADDR_DEF  = 8'h8B;
  localparam logic [7:0] TH0_ADDR_DEF  = 8'h8C;
  localparam logic [7:0] TH1_ADDR_DEF  = 8'h8D;
  localparam logic [7:0] TM0_ADDR_DEF  = 8'h94;
  localparam logic [7:0] TM1_ADDR_DEF  = 8'h95;

  // TMOD bit positions (8051 layout)
  localparam int TMOD_GATE1 = 7;
  localparam int TMOD_CT1   = 6;
  localparam int TMOD_M1_1  = 5;
  localparam int TMOD_M0_1  = 4;
  localparam int TMOD_GATE0 = 3;
  localparam int TMOD_CT0   = 2;
  localparam int TMOD_M1_0  = 1;
  localparam int TMOD_M0_0  = 0;

  // TCON bit positions
  localparam int TCON_TF1 = 7;
  localparam int TCON_TR1 = 6;
  localparam int TCON_TF0 = 5;
  localparam int TCON_TR0 = 4;

  // Timer mode encodings, M1:M0
  localparam logic [1:0] MODE_13BIT   = 2'b00;
  localparam logic [1:0] MODE_16BIT   = 2'b01;
  localparam logic [1:0] MODE_8BIT_AR = 2'b10;
  localparam logic [1:0] MODE_SPLIT   = 2'b11;

endpackage

`default_nettype wire

// File: rtl/timers_sfr_chan.sv
// ============================================================================
// Module   : timers_sfr_chan
// Brief    : One timer's TL/TM/TH count registers, TF flag next-state logic
//            and, when TIMERS_SFR_READ_LATCH_EN is defined, TM/TH read shadows
//            captured on a TL read for a coherent 24-bit read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timers_sfr_chan
  import timers_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wdata,
  input  logic       we_tl,
  input  logic       we_tm,
  input  logic       we_th,
  input  logic       we_tcon,
  input  logic       tf_wbit,
  input  logic       rd_tl,
  input  logic       ack,
  input  logic [7:0] tl_nxt,
  input  logic [7:0] tm_nxt,
  input  logic [7:0] th_nxt,
  input  logic       tf_nxt,
  output logic [7:0] tl,
  output logic [7:0] tm,
  output logic [7:0] th,
  output logic       tf,
  output logic [7:0] tm_rd,
  output logic [7:0] th_rd
);

  // Count bytes follow top_timers every cycle; a CPU write overrides only its byte.
  // TF: a fresh hardware overflow beats a TCON write, which beats an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      tl <= 8'h00;
      tm <= 8'h00;
      th <= 8'h00;
      tf <= 1'b0;
    end else begin
      tl <= we_tl ? wdata : tl_nxt;
      tm <= we_tm ? wdata : tm_nxt;
      th <= we_th ? wdata : th_nxt;
      if (tf_nxt && !tf) begin
        tf <= 1'b1;
      end else if (we_tcon) begin
        tf <= tf_wbit;
      end else if (ack) begin
        tf <= 1'b0;
      end else begin
        tf <= tf_nxt;
      end
    end
  end

`ifdef TIMERS_SFR_READ_LATCH_EN
  logic [7:0] sh_tm;
  logic [7:0] sh_th;

  // Snapshot TM/TH on a TL read; CPU writes to TM/TH keep the snapshot in step.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_tm <= 8'h00;
      sh_th <= 8'h00;
    end else begin
      if (rd_tl) begin
        sh_tm <= tm;
        sh_th <= th;
      end
      if (we_tm) sh_tm <= wdata;
      if (we_th) sh_th <= wdata;
    end
  end

  assign tm_rd = sh_tm;
  assign th_rd = sh_th;
`else
  logic unused_rd_tl;
  assign unused_rd_tl = rd_tl;
  assign tm_rd        = tm;
  assign th_rd        = th;
`endif

endmodule

`default_nettype wire

// File: rtl/timers_sfr_ctrl.sv
// ============================================================================
// Module   : timers_sfr_ctrl
// Brief    : SFR-side controller for the EMC08 Timer/Counter block. Owns TCON,
//            TMOD and the per-timer count bytes, decodes CPU SFR accesses,
//            feeds top_timers and raises timer interrupt requests.
//            Optional feature macro: TIMERS_SFR_READ_LATCH_EN (coherent
//            TL/TM/TH read via shadows).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timers_sfr_ctrl
  import timers_pkg::*;
#(
  parameter logic [7:0] TCON_ADDR = TCON_ADDR_DEF,
  parameter logic [7:0] TMOD_ADDR = TMOD_ADDR_DEF,
  parameter logic [7:0] TL0_ADDR  = TL0_ADDR_DEF,
  parameter logic [7:0] TL1_ADDR  = TL1_ADDR_DEF,
  parameter logic [7:0] TH0_ADDR  = TH0_ADDR_DEF,
  parameter logic [7:0] TH1_ADDR  = TH1_ADDR_DEF,
  parameter logic [7:0] TM0_ADDR  = TM0_ADDR_DEF,
  parameter logic [7:0] TM1_ADDR  = TM1_ADDR_DEF
) (
  input  logic       timers_sfr_ctrl_machine_cycle_i,
  input  logic       timers_sfr_ctrl_reset_i,
  input  logic [7:0] timers_sfr_ctrl_addr_i,
  input  logic [7:0] timers_sfr_ctrl_wdata_i,
  input  logic       timers_sfr_ctrl_we_i,
  input  logic       timers_sfr_ctrl_re_i,
  output logic [7:0] timers_sfr_ctrl_rdata_o,
  output logic       timers_sfr_ctrl_rvalid_o,
  output logic       timers_sfr_ctrl_hit_o,
  input  logic       timers_sfr_ctrl_int0_ack_i,
  input  logic       timers_sfr_ctrl_int1_ack_i,
  output logic       timers_sfr_ctrl_int0_req_o,
  output logic       timers_sfr_ctrl_int1_req_o,
  output logic       timers_sfr_ctrl_gate_t0_o,
  output logic       timers_sfr_ctrl_m0_t0_o,
  output logic       timers_sfr_ctrl_m1_t0_o,
  output logic       timers_sfr_ctrl_tr0_o,
  output logic       timers_sfr_ctrl_gate_t1_o,
  output logic       timers_sfr_ctrl_m0_t1_o,
  output logic       timers_sfr_ctrl_m1_t1_o,
  output logic       timers_sfr_ctrl_tr1_o,
  output logic [7:0] timers_sfr_ctrl_th0_o,
  output logic [7:0] timers_sfr_ctrl_tm0_o,
  output logic [7:0] timers_sfr_ctrl_tl0_o,
  output logic [7:0] timers_sfr_ctrl_th1_o,
  output logic [7:0] timers_sfr_ctrl_tm1_o,
  output logic [7:0] timers_sfr_ctrl_tl1_o,
  output logic       timers_sfr_ctrl_tf0_o,
  output logic       timers_sfr_ctrl_tf1_o,
  input  logic [7:0] timers_sfr_ctrl_th0_i,
  input  logic [7:0] timers_sfr_ctrl_tm0_i,
  input  logic [7:0] timers_sfr_ctrl_tl0_i,
  input  logic [7:0] timers_sfr_ctrl_th1_i,
  input  logic [7:0] timers_sfr_ctrl_tm1_i,
  input  logic [7:0] timers_sfr_ctrl_tl1_i,
  input  logic       timers_sfr_ctrl_tf0_i,
  input  logic       timers_sfr_ctrl_tf1_i,
  output logic [3:0] timers_sfr_ctrl_tcon_low_o
);

  logic       clk;
  logic       rst;
  logic [7:0] addr;
  logic [7:0] wdata;

  assign clk   = timers_sfr_ctrl_machine_cycle_i;
  assign rst   = timers_sfr_ctrl_reset_i;
  assign addr  = timers_sfr_ctrl_addr_i;
  assign wdata = timers_sfr_ctrl_wdata_i;

  // Address decode
  logic sel_tcon, sel_tmod, sel_tl0, sel_tl1, sel_th0, sel_th1, sel_tm0, sel_tm1;
  assign sel_tcon = (addr == TCON_ADDR);
  assign sel_tmod = (addr == TMOD_ADDR);
  assign sel_tl0  = (addr == TL0_ADDR);
  assign sel_tl1  = (addr == TL1_ADDR);
  assign sel_th0  = (addr == TH0_ADDR);
  assign sel_th1  = (addr == TH1_ADDR);
  assign sel_tm0  = (addr == TM0_ADDR);
  assign sel_tm1  = (addr == TM1_ADDR);

  logic hit;
  assign hit = sel_tcon | sel_tmod | sel_tl0 | sel_tl1 |
               sel_th0  | sel_th1  | sel_tm0 | sel_tm1;
  assign timers_sfr_ctrl_hit_o = hit;

  logic we;
  logic re;
  assign we = timers_sfr_ctrl_we_i;
  assign re = timers_sfr_ctrl_re_i;

  logic [7:0] tmod;
  logic       tr0;
  logic       tr1;
  logic [3:0] tcon_low;

  // TMOD and the software-only TCON bits take CPU writes directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmod     <= 8'h00;
      tr0      <= 1'b0;
      tr1      <= 1'b0;
      tcon_low <= 4'h0;
    end else begin
      if (we && sel_tmod) tmod <= wdata;
      if (we && sel_tcon) begin
        tr1      <= wdata[TCON_TR1];
        tr0      <= wdata[TCON_TR0];
        tcon_low <= wdata[3:0];
      end
    end
  end

  logic [7:0] tl0, tm0, th0, tl1, tm1, th1;
  logic [7:0] tm0_rd, th0_rd, tm1_rd, th1_rd;
  logic       tf0, tf1;

  timers_sfr_chan u_chan0 (
    .clk     (clk),
    .rst     (rst),
    .wdata   (wdata),
    .we_tl   (we && sel_tl0),
    .we_tm   (we && sel_tm0),
    .we_th   (we && sel_th0),
    .we_tcon (we && sel_tcon),
    .tf_wbit (wdata[TCON_TF0]),
    .rd_tl   (re && sel_tl0),
    .ack     (timers_sfr_ctrl_int0_ack_i),
    .tl_nxt  (timers_sfr_ctrl_tl0_i),
    .tm_nxt  (timers_sfr_ctrl_tm0_i),
    .th_nxt  (timers_sfr_ctrl_th0_i),
    .tf_nxt  (timers_sfr_ctrl_tf0_i),
    .tl      (tl0),
    .tm      (tm0),
    .th      (th0),
    .tf      (tf0),
    .tm_rd   (tm0_rd),
    .th_rd   (th0_rd)
  );

  timers_sfr_chan u_chan1 (
    .clk     (clk),
    .rst     (rst),
    .wdata   (wdata),
    .we_tl   (we && sel_tl1),
    .we_tm   (we && sel_tm1),
    .we_th   (we && sel_th1),
    .we_tcon (we && sel_tcon),
    .tf_wbit (wdata[TCON_TF1]),
    .rd_tl   (re && sel_tl1),
    .ack     (timers_sfr_ctrl_int1_ack_i),
    .tl_nxt  (timers_sfr_ctrl_tl1_i),
    .tm_nxt  (timers_sfr_ctrl_tm1_i),
    .th_nxt  (timers_sfr_ctrl_th1_i),
    .tf_nxt  (timers_sfr_ctrl_tf1_i),
    .tl      (tl1),
    .tm      (tm1),
    .th      (th1),
    .tf      (tf1),
    .tm_rd   (tm1_rd),
    .th_rd   (th1_rd)
  );

  logic [7:0] tcon;
  assign tcon = {tf1, tr1, tf0, tr0, tcon_low};

  // Read mux over current (pre-write) register state; unmapped reads give 0.
  logic [7:0] rmux;
  always_comb begin
    rmux = 8'h00;
    if (sel_tcon)     rmux = tcon;
    else if (sel_tmod) rmux = tmod;
    else if (sel_tl0)  rmux = tl0;
    else if (sel_tl1)  rmux = tl1;
    else if (sel_th0)  rmux = th0_rd;
    else if (sel_th1)  rmux = th1_rd;
    else if (sel_tm0)  rmux = tm0_rd;
    else if (sel_tm1)  rmux = tm1_rd;
  end

  logic [7:0] rdata;
  logic       rvalid;

  // Registered read return: one-cycle rvalid pulse per read strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= 8'h00;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      rdata  <= re ? rmux : 8'h00;
    end
  end

  assign timers_sfr_ctrl_rdata_o    = rdata;
  assign timers_sfr_ctrl_rvalid_o   = rvalid;
  assign timers_sfr_ctrl_int0_req_o = tf0;
  assign timers_sfr_ctrl_int1_req_o = tf1;
  assign timers_sfr_ctrl_tf0_o      = tf0;
  assign timers_sfr_ctrl_tf1_o      = tf1;
  assign timers_sfr_ctrl_tr0_o      = tr0;
  assign timers_sfr_ctrl_tr1_o      = tr1;
  assign timers_sfr_ctrl_gate_t0_o  = tmod[TMOD_GATE0];
  assign timers_sfr_ctrl_m0_t0_o    = tmod[TMOD_M0_0];
  assign timers_sfr_ctrl_m1_t0_o    = tmod[TMOD_M1_0];
  assign timers_sfr_ctrl_gate_t1_o  = tmod[TMOD_GATE1];
  assign timers_sfr_ctrl_m0_t1_o    = tmod[TMOD_M0_1];
  assign timers_sfr_ctrl_m1_t1_o    = tmod[TMOD_M1_1];
  assign timers_sfr_ctrl_th0_o      = th0;
  assign timers_sfr_ctrl_tm0_o      = tm0;
  assign timers_sfr_ctrl_tl0_o      = tl0;
  assign timers_sfr_ctrl_th1_o      = th1;
  assign timers_sfr_ctrl_tm1_o      = tm1;
  assign timers_sfr_ctrl_tl1_o      = tl1;
  assign timers_sfr_ctrl_tcon_low_o = tcon_low;

endmodule

`default_nettype wire

// File: tb/tb_timers_sfr_ctrl.sv
// ============================================================================
// Module   : tb_timers_sfr_ctrl
// Brief    : Self-checking bench for timers_sfr_ctrl. The reference model is
//            an address-indexed SFR byte map updated once per machine cycle.
//            Honors TIMERS_SFR_READ_LATCH_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timers_sfr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr, wdata;
  logic       we, re, ack0, ack1;
  logic [7:0] th0_i, tm0_i, tl0_i, th1_i, tm1_i, tl1_i;
  logic       tf0_i, tf1_i;

  logic [7:0] rdata;
  logic       rvalid, hit, int0_req, int1_req;
  logic       gate_t0, m0_t0, m1_t0, tr0, gate_t1, m0_t1, m1_t1, tr1;
  logic [7:0] th0, tm0, tl0, th1, tm1, tl1;
  logic       tf0, tf1;
  logic [3:0] tcon_low;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  timers_sfr_ctrl dut (
    .timers_sfr_ctrl_machine_cycle_i (clk),
    .timers_sfr_ctrl_reset_i         (rst),
    .timers_sfr_ctrl_addr_i          (addr),
    .timers_sfr_ctrl_wdata_i         (wdata),
    .timers_sfr_ctrl_we_i            (we),
    .timers_sfr_ctrl_re_i            (re),
    .timers_sfr_ctrl_rdata_o         (rdata),
    .timers_sfr_ctrl_rvalid_o        (rvalid),
    .timers_sfr_ctrl_hit_o           (hit),
    .timers_sfr_ctrl_int0_ack_i      (ack0),
    .timers_sfr_ctrl_int1_ack_i      (ack1),
    .timers_sfr_ctrl_int0_req_o      (int0_req),
    .timers_sfr_ctrl_int1_req_o      (int1_req),
    .timers_sfr_ctrl_gate_t0_o       (gate_t0),
    .timers_sfr_ctrl_m0_t0_o         (m0_t0),
    .timers_sfr_ctrl_m1_t0_o         (m1_t0),
    .timers_sfr_ctrl_tr0_o           (tr0),
    .timers_sfr_ctrl_gate_t1_o       (gate_t1),
    .timers_sfr_ctrl_m0_t1_o         (m0_t1),
    .timers_sfr_ctrl_m1_t1_o         (m1_t1),
    .timers_sfr_ctrl_tr1_o           (tr1),
    .timers_sfr_ctrl_th0_o           (th0),
    .timers_sfr_ctrl_tm0_o           (tm0),
    .timers_sfr_ctrl_tl0_o           (tl0),
    .timers_sfr_ctrl_th1_o           (th1),
    .timers_sfr_ctrl_tm1_o           (tm1),
    .timers_sfr_ctrl_tl1_o           (tl1),
    .timers_sfr_ctrl_tf0_o           (tf0),
    .timers_sfr_ctrl_tf1_o           (tf1),
    .timers_sfr_ctrl_th0_i           (th0_i),
    .timers_sfr_ctrl_tm0_i           (tm0_i),
    .timers_sfr_ctrl_tl0_i           (tl0_i),
    .timers_sfr_ctrl_th1_i           (th1_i),
    .timers_sfr_ctrl_tm1_i           (tm1_i),
    .timers_sfr_ctrl_tl1_i           (tl1_i),
    .timers_sfr_ctrl_tf0_i           (tf0_i),
    .timers_sfr_ctrl_tf1_i           (tf1_i),
    .timers_sfr_ctrl_tcon_low_o      (tcon_low)
  );

  // ---------------- reference model: SFR byte map ----------------
  logic [7:0] m [0:255];
  logic [7:0] sh_tm [0:1];
  logic [7:0] sh_th [0:1];
  logic [7:0] exp_rdata;
  logic       exp_rvalid;

  localparam logic [7:0] A_TCON = 8'h88;
  localparam logic [7:0] A_TMOD = 8'h89;
  logic [7:0] a_tl [0:1] = '{8'h8A, 8'h8B};
  logic [7:0] a_th [0:1] = '{8'h8C, 8'h8D};
  logic [7:0] a_tm [0:1] = '{8'h94, 8'h95};
  logic [7:0] a_map [0:7] = '{8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D, 8'h94, 8'h95};

  function automatic logic mapped(input logic [7:0] a);
    for (int i = 0; i < 8; i++) if (a_map[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (!mapped(a)) return 8'h00;
`ifdef TIMERS_SFR_READ_LATCH_EN
    for (int i = 0; i < 2; i++) begin
      if (a == a_tm[i]) return sh_tm[i];
      if (a == a_th[i]) return sh_th[i];
    end
`endif
    return m[a];
  endfunction

  function automatic logic [72:0] obs_vec();
    return {rdata, rvalid, int0_req, int1_req, gate_t0, m0_t0, m1_t0, tr0,
            gate_t1, m0_t1, m1_t1, tr1, th0, tm0, tl0, th1, tm1, tl1, tf0, tf1, tcon_low};
  endfunction

  function automatic logic [72:0] exp_vec();
    logic [7:0] tc, tm;
    tc = m[A_TCON];
    tm = m[A_TMOD];
    return {exp_rdata, exp_rvalid, tc[5], tc[7], tm[3], tm[0], tm[1], tc[4],
            tm[7], tm[4], tm[5], tc[6], m[8'h8C], m[8'h94], m[8'h8A],
            m[8'h8D], m[8'h95], m[8'h8B], tc[5], tc[7], tc[3:0]};
  endfunction

  // Advance one machine cycle: update the model from current inputs, clock the DUT.
  task automatic step();
    logic [7:0] tin [0:1][0:2];
    logic       tfi [0:1];
    logic       ackv [0:1];
    logic       tf_old, tf_new [0:1];
    tin[0][0] = tl0_i; tin[0][1] = tm0_i; tin[0][2] = th0_i;
    tin[1][0] = tl1_i; tin[1][1] = tm1_i; tin[1][2] = th1_i;
    tfi[0] = tf0_i; tfi[1] = tf1_i;
    ackv[0] = ack0; ackv[1] = ack1;
    if (rst) begin
      exp_rdata = 8'h00; exp_rvalid = 1'b0;
      for (int i = 0; i < 256; i++) m[i] = 8'h00;
      for (int i = 0; i < 2; i++) begin sh_tm[i] = 8'h00; sh_th[i] = 8'h00; end
    end else begin
      exp_rvalid = re;
      exp_rdata  = re ? model_read(addr) : 8'h00;
      for (int i = 0; i < 2; i++) begin
        tf_old = m[A_TCON][5 + 2*i];
        if (tfi[i] && !tf_old)          tf_new[i] = 1'b1;
        else if (we && addr == A_TCON)  tf_new[i] = wdata[5 + 2*i];
        else if (ackv[i])               tf_new[i] = 1'b0;
        else                            tf_new[i] = tfi[i];
        if (re && addr == a_tl[i]) begin
          sh_tm[i] = m[a_tm[i]];
          sh_th[i] = m[a_th[i]];
        end
        m[a_tl[i]] = tin[i][0];
        m[a_tm[i]] = tin[i][1];
        m[a_th[i]] = tin[i][2];
      end
      if (we && mapped(addr)) begin
        m[addr] = wdata;
        for (int i = 0; i < 2; i++) begin
          if (addr == a_tm[i]) sh_tm[i] = wdata;
          if (addr == a_th[i]) sh_th[i] = wdata;
        end
      end
      m[A_TCON][5] = tf_new[0];
      m[A_TCON][7] = tf_new[1];
    end
    @(posedge clk);
    #1;
  endtask

  // Idle bus, top_timers holding its present count (stopped timer).
  task automatic hold();
    rst = 1'b0; we = 1'b0; re = 1'b0; ack0 = 1'b0; ack1 = 1'b0;
    addr = 8'h00; wdata = 8'h00;
    tl0_i = m[8'h8A]; tm0_i = m[8'h94]; th0_i = m[8'h8C]; tf0_i = m[A_TCON][5];
    tl1_i = m[8'h8B]; tm1_i = m[8'h95]; th1_i = m[8'h8D]; tf1_i = m[A_TCON][7];
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    hold();
    rst = 1'b1; we = 1'b1; addr = 8'h8A; wdata = 8'hFF;
    tl0_i = 8'h5A; tf0_i = 1'b1; tf1_i = 1'b1;
    step();
    total++;
    if (obs_vec() !== 73'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", obs_vec());
    end
    hold(); re = 1'b1; addr = 8'h8A;
    step();
    total++;
    if (rdata !== 8'h00 || rvalid !== 1'b1) begin
      bad++; $display("FAIL reset_tl0_read got=%h/%b want=00/1", rdata, rvalid);
    end
  endtask

  task automatic test_write_read();
    hold(); we = 1'b1; addr = A_TMOD; wdata = 8'hA5;
    step();
    total++;
    if ({m0_t0, m1_t1, gate_t1, m1_t0, gate_t0, m0_t1} !== 6'b111000) begin
      bad++; $display("FAIL tmod_bits got=%b want=111000", {m0_t0, m1_t1, gate_t1, m1_t0, gate_t0, m0_t1});
    end
    hold(); we = 1'b1; addr = 8'h8C; wdata = 8'h12;
    step();
    hold(); re = 1'b1; addr = A_TMOD;
    step();
    total++;
    if (rdata !== 8'hA5 || rvalid !== 1'b1) begin
      bad++; $display("FAIL tmod_read got=%h/%b want=a5/1", rdata, rvalid);
    end
    hold(); re = 1'b1; addr = 8'h8C;
    step();
    total++;
    if (rdata !== 8'h12 || rvalid !== 1'b1) begin
      bad++; $display("FAIL th0_read got=%h/%b want=12/1", rdata, rvalid);
    end
    hold(); addr = 8'h77;
    #1;
    total++;
    if (hit !== 1'b0) begin bad++; $display("FAIL hit_unmapped got=%b want=0", hit); end
    re = 1'b1;
    step();
    total++;
    if (rdata !== 8'h00 || rvalid !== 1'b1) begin
      bad++; $display("FAIL unmapped_read got=%h/%b want=00/1", rdata, rvalid);
    end
    hold();
    step();
    total++;
    if (rvalid !== 1'b0) begin bad++; $display("FAIL rvalid_pulse got=%b want=0", rvalid); end
  endtask

  task automatic test_byte_precedence();
    hold(); we = 1'b1; addr = 8'h8A; wdata = 8'hFF; tl0_i = 8'h01; tm0_i = 8'h06;
    step();
    total++;
    if (tl0 !== 8'hFF || tm0 !== 8'h06) begin
      bad++; $display("FAIL byte_precedence got=%h/%h want=ff/06", tl0, tm0);
    end
    hold(); we = 1'b1; re = 1'b1; addr = 8'h8A; wdata = 8'h3C;
    step();
    total++;
    if (rdata !== 8'hFF || tl0 !== 8'h3C) begin
      bad++; $display("FAIL read_pre_write got=%h/%h want=ff/3c", rdata, tl0);
    end
  endtask

  task automatic test_interrupt();
    hold(); tf0_i = 1'b1;
    step();
    total++;
    if (int0_req !== 1'b1) begin bad++; $display("FAIL int0_set got=%b want=1", int0_req); end
    hold(); ack0 = 1'b1;
    step();
    total++;
    if (int0_req !== 1'b0) begin bad++; $display("FAIL int0_ack got=%b want=0", int0_req); end
    hold(); ack0 = 1'b1; tf0_i = 1'b1;
    step();
    total++;
    if (int0_req !== 1'b1) begin bad++; $display("FAIL int0_ack_ovf got=%b want=1", int0_req); end
    hold(); ack0 = 1'b1; tf0_i = 1'b0;
    step();
    hold(); tf1_i = 1'b1;
    step();
    total++;
    if (int1_req !== 1'b1 || int0_req !== 1'b0) begin
      bad++; $display("FAIL int1_set got=%b%b want=10", int1_req, int0_req);
    end
    hold(); ack1 = 1'b1; tf1_i = 1'b0;
    step();
  endtask

  task automatic test_tcon_race();
    hold(); we = 1'b1; addr = A_TCON; wdata = 8'h10; tf0_i = 1'b1;
    step();
    total++;
    if (tf0 !== 1'b1 || tr0 !== 1'b1) begin
      bad++; $display("FAIL tcon_race got=%b%b want=11", tf0, tr0);
    end
    hold(); we = 1'b1; addr = A_TCON; wdata = 8'h0A; tf0_i = 1'b0;
    step();
    total++;
    if (tf0 !== 1'b0 || tr0 !== 1'b0 || tcon_low !== 4'hA) begin
      bad++; $display("FAIL tcon_sw_clear got=%b%b%h want=00a", tf0, tr0, tcon_low);
    end
  endtask

  task automatic test_latch();
    logic [7:0] want;
    hold(); we = 1'b1; addr = 8'h8A; wdata = 8'h34; step();
    hold(); we = 1'b1; addr = 8'h94; wdata = 8'h56; step();
    hold(); we = 1'b1; addr = 8'h8C; wdata = 8'h78; step();
    hold(); re = 1'b1; addr = 8'h8A;
    step();
    total++;
    if (rdata !== 8'h34) begin bad++; $display("FAIL latch_tl0 got=%h want=34", rdata); end
    hold(); th0_i = 8'h79;
    step();
    hold(); re = 1'b1; addr = 8'h8C;
    step();
`ifdef TIMERS_SFR_READ_LATCH_EN
    want = 8'h78;
`else
    want = 8'h79;
`endif
    total++;
    if (rdata !== want) begin bad++; $display("FAIL latch_th0 got=%h want=%h", rdata, want); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 59) == 0);
      we    = $urandom_range(0, 2) == 0;
      re    = $urandom_range(0, 1) == 1;
      ack0  = $urandom_range(0, 3) == 0;
      ack1  = $urandom_range(0, 3) == 0;
      addr  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : a_map[$urandom_range(0, 7)];
      wdata = 8'($urandom);
      tl0_i = 8'($urandom); tm0_i = 8'($urandom); th0_i = 8'($urandom);
      tl1_i = 8'($urandom); tm1_i = 8'($urandom); th1_i = 8'($urandom);
      tf0_i = $urandom_range(0, 3) == 0;
      tf1_i = $urandom_range(0, 3) == 0;
      #1;
      total++;
      if (hit !== mapped(addr)) begin
        bad++; $display("FAIL rand_hit n=%0d addr=%h got=%b want=%b", n, addr, hit, mapped(addr));
      end
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL rand_state n=%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m[i] = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_byte_precedence();
    test_interrupt();
    test_tcon_race();
    test_latch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
